// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/execute
// states and drives register enables, mux selects, immediate type and ALU operation.
module multicycle_controller #(
    parameter int STATE_W  = 4,
    parameter bit ERR_HALT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         func3,
    input  logic [6:0]         func7,
    input  logic               zero,
    output logic               pcwrite,
    output logic               adrsrc,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic [1:0]         resultsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         extend_func,
    output logic [2:0]         aluop,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);
    typedef enum logic [STATE_W-1:0] {
        FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5,
        EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR = 11,
        LUI = 12, ERROR = 13
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                           ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_SLTU = 3'd6, ALU_PASSB = 3'd7;
    localparam logic [2:0] EXT_I = 3'd0, EXT_S = 3'd1, EXT_B = 3'd2, EXT_J = 3'd3, EXT_U = 3'd4;

    state_t state, state_next;
    logic   pcw_c, memw_c, irw_c, regw_c, ill_c;
    logic   fn_ok, taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next  = state;
        pcw_c       = 1'b0;
        memw_c      = 1'b0;
        irw_c       = 1'b0;
        regw_c      = 1'b0;
        ill_c       = 1'b0;
        adrsrc      = 1'b0;
        resultsrc   = 2'b00;
        alusrca     = 2'b00;
        alusrcb     = 2'b00;
        extend_func = EXT_I;
        aluop       = ALU_ADD;
        fn_ok       = 1'b1;
        taken       = 1'b0;
        case (state)
            FETCH: begin
                irw_c = 1'b1; pcw_c = 1'b1;
                alusrcb = 2'b10; resultsrc = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                // ALUOut <= oldPC + imm: branch target, or jump target for jal
                alusrca = 2'b01; alusrcb = 2'b01;
                extend_func = (op == OP_JAL) ? EXT_J : EXT_B;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_B:         state_next = BRANCH;
                    OP_JAL:       state_next = JAL;
                    OP_JALR:      state_next = JALR;
                    OP_LUI:       state_next = LUI;
                    default:      state_next = ERROR;
                endcase
            end
            MEMADR: begin
                alusrca = 2'b10; alusrcb = 2'b01;
                extend_func = (op == OP_SW) ? EXT_S : EXT_I;
                state_next  = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adrsrc = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                resultsrc = 2'b01; regw_c = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adrsrc = 1'b1; memw_c = 1'b1;
                state_next = FETCH;
            end
            EXECR: begin
                alusrca = 2'b10;
                case (func3)
                    3'b000: aluop = func7[5] ? ALU_SUB : ALU_ADD;
                    3'b111: aluop = ALU_AND;
                    3'b110: aluop = ALU_OR;
                    3'b100: aluop = ALU_XOR;
                    3'b010: aluop = ALU_SLT;
                    3'b011: aluop = ALU_SLTU;
                    default: fn_ok = 1'b0;
                endcase
                if (func3 != 3'b000 && func7 != 7'b0) fn_ok = 1'b0;
                state_next = fn_ok ? ALUWB : ERROR;
            end
            EXECI: begin
                alusrca = 2'b10; alusrcb = 2'b01;
                case (func3)
                    3'b000: aluop = ALU_ADD;
                    3'b100: aluop = ALU_XOR;
                    3'b110: aluop = ALU_OR;
                    3'b111: aluop = ALU_AND;
                    3'b010: aluop = ALU_SLT;
                    3'b011: aluop = ALU_SLTU;
                    default: fn_ok = 1'b0;
                endcase
                state_next = fn_ok ? ALUWB : ERROR;
            end
            ALUWB: begin
                regw_c = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alusrca = 2'b10;
                // ge/geu flavours take the branch when the compare result is zero
                case (func3)
                    3'b000: begin aluop = ALU_SUB;  taken = zero;  end
                    3'b001: begin aluop = ALU_SUB;  taken = !zero; end
                    3'b100: begin aluop = ALU_SLT;  taken = !zero; end
                    3'b101: begin aluop = ALU_SLT;  taken = zero;  end
                    3'b110: begin aluop = ALU_SLTU; taken = !zero; end
                    3'b111: begin aluop = ALU_SLTU; taken = zero;  end
                    default: fn_ok = 1'b0;
                endcase
                pcw_c = taken;
                state_next = fn_ok ? FETCH : ERROR;
            end
            JAL: begin
                pcw_c = 1'b1;
                alusrca = 2'b01; alusrcb = 2'b10;
                state_next = ALUWB;
            end
            JALR: begin
                alusrca = 2'b10; alusrcb = 2'b01;
                state_next = JAL;
            end
            LUI: begin
                alusrcb = 2'b01; extend_func = EXT_U; aluop = ALU_PASSB;
                state_next = ALUWB;
            end
            ERROR: begin
                ill_c = 1'b1;
                state_next = ERR_HALT ? ERROR : FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset holds state at FETCH; enables are gated so nothing writes while rst is low
    assign pcwrite   = rst & pcw_c;
    assign memwrite  = rst & memw_c;
    assign irwrite   = rst & irw_c;
    assign regwrite  = rst & regw_c;
    assign illegal   = rst & ill_c;
    assign state_dbg = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle control vector; ERR_HALT=1 and 0 run side by side.
module tb_multicycle_controller;
    logic       clk = 1'b0, rst = 1'b0, zero = 1'b0;
    logic [6:0] op = '0, func7 = '0;
    logic [2:0] func3 = '0;

    logic       h_pcw, h_adr, h_mw, h_iw, h_rw, h_ill, s_pcw, s_adr, s_mw, s_iw, s_rw, s_ill;
    logic [1:0] h_rs, h_sa, h_sb, s_rs, s_sa, s_sb;
    logic [2:0] h_ext, h_alu, s_ext, s_alu;
    logic [3:0] h_st, s_st;

    multicycle_controller #(.STATE_W(4), .ERR_HALT(1'b1)) dut_h (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .pcwrite(h_pcw), .adrsrc(h_adr), .memwrite(h_mw), .irwrite(h_iw), .regwrite(h_rw),
        .resultsrc(h_rs), .alusrca(h_sa), .alusrcb(h_sb), .extend_func(h_ext), .aluop(h_alu),
        .illegal(h_ill), .state_dbg(h_st));
    multicycle_controller #(.STATE_W(4), .ERR_HALT(1'b0)) dut_s (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .pcwrite(s_pcw), .adrsrc(s_adr), .memwrite(s_mw), .irwrite(s_iw), .regwrite(s_rw),
        .resultsrc(s_rs), .alusrca(s_sa), .alusrcb(s_sb), .extend_func(s_ext), .aluop(s_alu),
        .illegal(s_ill), .state_dbg(s_st));

    wire [21:0] h_vec = {h_st, h_pcw, h_adr, h_mw, h_iw, h_rw, h_rs, h_sa, h_sb, h_ext, h_alu, h_ill};
    wire [21:0] s_vec = {s_st, s_pcw, s_adr, s_mw, s_iw, s_rw, s_rs, s_sa, s_sb, s_ext, s_alu, s_ill};

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [21:0] trace[$];
    logic        zs[8];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {state, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb, ext, aluop, illegal}
    function automatic logic [21:0] mk(int st, int pw, int ad, int mw, int iw, int rw,
                                       int rs, int sa, int sb, int ex, int al, int il);
        return {4'(st), 1'(pw), 1'(ad), 1'(mw), 1'(iw), 1'(rw), 2'(rs), 2'(sa), 2'(sb),
                3'(ex), 3'(al), 1'(il)};
    endfunction

    localparam logic [21:0] V_FETCH = 22'({4'd0, 5'b10010, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0});
    localparam logic [21:0] V_ALUWB = 22'({4'd8, 5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0});
    localparam logic [21:0] V_ERR   = 22'({4'd13, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1});
    localparam logic [21:0] V_RST   = 22'({4'd0, 5'b00000, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0});

    // Expand one instruction into its expected cycle-by-cycle control vectors
    task automatic build(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        int  alu;
        bit  ok, tk;
        trace.delete();
        trace.push_back(V_FETCH);
        trace.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, (o == 7'h6F) ? 3 : 2, 0, 0));
        alu = 0; ok = 1; tk = 0;
        case (o)
            7'h03: begin
                trace.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
                trace.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                trace.push_back(mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
            end
            7'h23: begin
                trace.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0));
                trace.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            7'h33: begin
                case (f3)
                    3'd0: alu = f7[5] ? 1 : 0;
                    3'd7: alu = 2;  3'd6: alu = 3;  3'd4: alu = 4;
                    3'd2: alu = 5;  3'd3: alu = 6;
                    default: ok = 0;
                endcase
                if (f3 != 0 && f7 != 0) ok = 0;
                trace.push_back(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, alu, 0));
                trace.push_back(ok ? V_ALUWB : V_ERR);
            end
            7'h13: begin
                case (f3)
                    3'd0: alu = 0;  3'd4: alu = 4;  3'd6: alu = 3;
                    3'd7: alu = 2;  3'd2: alu = 5;  3'd3: alu = 6;
                    default: ok = 0;
                endcase
                trace.push_back(mk(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, alu, 0));
                trace.push_back(ok ? V_ALUWB : V_ERR);
            end
            7'h63: begin
                case (f3)
                    3'd0: begin alu = 1; tk = zs[2];  end  // beq
                    3'd1: begin alu = 1; tk = !zs[2]; end  // bne
                    3'd4: begin alu = 5; tk = !zs[2]; end  // blt
                    3'd5: begin alu = 5; tk = zs[2];  end  // bge
                    3'd6: begin alu = 6; tk = !zs[2]; end  // bltu
                    3'd7: begin alu = 6; tk = zs[2];  end  // bgeu
                    default: ok = 0;
                endcase
                trace.push_back(mk(9, tk, 0, 0, 0, 0, 0, 2, 0, 0, alu, 0));
                if (!ok) trace.push_back(V_ERR);
            end
            7'h6F: begin
                trace.push_back(mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
                trace.push_back(V_ALUWB);
            end
            7'h67: begin
                trace.push_back(mk(11, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
                trace.push_back(mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
                trace.push_back(V_ALUWB);
            end
            7'h37: begin
                trace.push_back(mk(12, 0, 0, 0, 0, 0, 0, 0, 1, 4, 7, 0));
                trace.push_back(V_ALUWB);
            end
            default: trace.push_back(V_ERR);
        endcase
    endtask

    // Called and returns just after a rising edge; leaves the FSM in FETCH
    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_h", h_vec, V_RST);
        chk("rst_s", s_vec, V_RST);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                             int zf, int abort_at = -1);
        for (int i = 0; i < 8; i++) zs[i] = (zf < 0) ? 1'($urandom % 2) : zf[0];
        build(o, f3, f7);
        for (int i = 0; i < trace.size(); i++) begin
            op = o; func3 = f3; func7 = f7; zero = zs[i];
            @(negedge clk);
            chk($sformatf("%s/h%0d", name, i), h_vec, trace[i]);
            chk($sformatf("%s/s%0d", name, i), s_vec, trace[i]);
            if (i == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk($sformatf("%s/abort_h", name), h_vec, V_RST);
                chk($sformatf("%s/abort_s", name), s_vec, V_RST);
                @(posedge clk); #1;
                do_reset();
                return;
            end
            @(posedge clk); #1;
        end
        if (trace[trace.size()-1][21:18] == 4'd13) begin
            @(negedge clk);
            chk($sformatf("%s/halt", name), h_vec, V_ERR);
            chk($sformatf("%s/recover", name), s_vec, V_FETCH);
            @(posedge clk); #1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("%s/halt%0d", name, k), h_vec, V_ERR);
                @(posedge clk); #1;
            end
            do_reset();
        end
    endtask

    initial begin
        logic [6:0] ops[10];
        logic [6:0] f7r;
        int         sel;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h00, 7'h00};
        @(posedge clk); #1;
        do_reset();
        run_instr("add",   7'h33, 3'd0, 7'h00, -1);
        run_instr("sub",   7'h33, 3'd0, 7'h20, -1);
        run_instr("lw",    7'h03, 3'd2, 7'h00, -1);
        run_instr("sw",    7'h23, 3'd2, 7'h00, -1);
        run_instr("bne_z1", 7'h63, 3'd1, 7'h00, 1);
        run_instr("bne_z0", 7'h63, 3'd1, 7'h00, 0);
        run_instr("bltu",  7'h63, 3'd6, 7'h00, 0);
        run_instr("jalr",  7'h67, 3'd0, 7'h00, -1);
        run_instr("jal",   7'h6F, 3'd0, 7'h00, -1);
        run_instr("lui",   7'h37, 3'd0, 7'h00, -1);
        run_instr("ill_op", 7'h7F, 3'd0, 7'h00, -1);
        run_instr("slli",  7'h13, 3'd1, 7'h00, -1);
        run_instr("and_f7", 7'h33, 3'd7, 7'h20, -1);
        run_instr("br_bad", 7'h63, 3'd2, 7'h00, 1);
        run_instr("sw_abort", 7'h23, 3'd2, 7'h00, -1, 3);
        run_instr("add2",  7'h33, 3'd0, 7'h00, -1);
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom % 10);
            if (sel >= 8) ops[sel] = 7'($urandom);
            f7r = 7'($urandom);
            case ($urandom % 4)
                0: f7r = 7'h00;
                1: f7r = 7'h20;
                2: f7r = 7'h00;
                default: ;
            endcase
            run_instr($sformatf("rnd%0d", n), ops[sel], 3'($urandom), f7r, -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I datapath: one unified memory, instruction register (IR), old-PC register, A/B operand registers, ALUOut register, and a memory-data register (Data).
- Each cycle it decodes op/func3/func7 from IR and the ALU zero flag, and drives the register enables, mux selects, immediate-extend function and ALU operation.
- It sits beside the datapath at top level and replaces the single-cycle combinational decoder.

Parameters:
- STATE_W, 4, width of the state register.
- ERR_HALT, 1. When 1, an illegal instruction parks the FSM in ERROR until reset. When 0, ERROR lasts one cycle, then the FSM returns to FETCH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- op  in  7  IR[6:0].
- func3  in  3  IR[14:12].
- func7  in  7  IR[31:25].
- zero  in  1  ALU zero flag, combinational, current cycle.
- pcwrite  out  1  PC load enable.
- adrsrc  out  1  memory address select: 0=PC, 1=result.
- memwrite  out  1  memory write enable.
- irwrite  out  1  IR and old-PC load enable.
- regwrite  out  1  register-file write enable.
- resultsrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALU result.
- alusrca  out  2  ALU A select: 00=PC, 01=oldPC, 10=A.
- alusrcb  out  2  ALU B select: 00=B, 01=imm, 10=const 4.
- extend_func  out  3  immediate type: 000=I, 001=S, 010=B, 011=J, 100=U.
- aluop  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 pass-B.
- illegal  out  1  high while in ERROR (sticky when ERR_HALT=1).
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, ERROR=13.
- Register update:
  - The state register is the only flop.
  - rst low forces state=FETCH asynchronously.
  - While rst is low, pcwrite, irwrite, memwrite and regwrite are forced to 0 and illegal=0.
  - All other outputs take their FETCH values during reset.
- Outputs are combinational from state, op and func fields. pcwrite in BRANCH also depends on zero.
- Any output not listed for a state is 0 in that state.
- FETCH:
  - adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=10, pcwrite=1.
  - Next state: DECODE.
- DECODE:
  - alusrca=01, alusrcb=01, extend_func=B, aluop=add, which precomputes the branch target into ALUOut.
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; any other op -> ERROR.
  - In JAL, extend_func=J so the decode-time target is PC+J-imm.
- MEMADR:
  - alusrca=10, alusrcb=01, aluop=add.
  - extend_func=I for lw, S for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: resultsrc=00, adrsrc=1; next state MEMWB.
- MEMWB: resultsrc=01, regwrite=1; next state FETCH.
- MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1; next state FETCH.
- EXECR:
  - alusrca=10, alusrcb=00.
  - func3 decode: 000 -> add if func7[5]=0, sub if 1; 111 and; 110 or; 100 xor; 010 slt; 011 sltu.
  - For the non-000 func3 codes, func7 must be 0000000; anything else -> ERROR.
  - Next state: ALUWB.
- EXECI:
  - alusrca=10, alusrcb=01, extend_func=I.
  - func3 decode: 000 add, 100 xor, 110 or, 111 and, 010 slt, 011 sltu.
  - func3 001 or 101 -> ERROR.
  - Next state: ALUWB.
- ALUWB: resultsrc=00, regwrite=1; next state FETCH.
- BRANCH:
  - alusrca=10, alusrcb=00, resultsrc=00.
  - func3 decode: 000 beq (sub, taken=zero); 001 bne (sub, taken=!zero); 100 blt (slt, taken=!zero); 101 bge (slt, taken=zero); 110 bltu (sltu, taken=!zero); 111 bgeu (sltu, taken=zero).
  - pcwrite=taken. func3 010 or 011 -> ERROR with pcwrite=0.
  - Next state: FETCH.
- JAL:
  - pcwrite=1, resultsrc=00 (PC<=target), alusrca=01, alusrcb=10, aluop=add (ALUOut<=oldPC+4).
  - Next state: ALUWB.
- JALR:
  - alusrca=10, alusrcb=01, extend_func=I, aluop=add (ALUOut<=rs1+imm).
  - Next state: JAL.
- LUI: alusrcb=01, extend_func=U, aluop=pass-B; next state ALUWB.
- ERROR:
  - All enables 0, illegal=1.
  - Stays in ERROR when ERR_HALT=1; goes to FETCH when ERR_HALT=0.
- Cycle counts: R/I/sw/jal/lui 4, lw 5, jalr 5, branch 3.
- Reset asserted mid-instruction aborts the instruction. No write enable fires after rst falls.

Test Plan:
- Reset: rst low for 2 cycles, then high -> state_dbg=0, irwrite=1 and pcwrite=1 in the first cycle after release.
- add then sub (op=0110011, func3=000, func7=0 then 0100000): state sequence 0,1,6,8; aluop 000 then 001; regwrite=1 only in ALUWB.
- lw (op=0000011): sequence 0,1,2,3,4; extend_func=000 in MEMADR; resultsrc=01 with regwrite=1 in MEMWB.
- sw (op=0100011): sequence 0,1,2,5; memwrite=1 only in MEMWRITE, with extend_func=001 in MEMADR.
- bne (func3=001) with zero=1, then with zero=0 -> pcwrite=0 and pcwrite=1 respectively in BRANCH.
- bltu (func3=110): aluop=110 in BRANCH; zero=0 -> pcwrite=1.
- jalr: sequence 0,1,11,10,8 -> pcwrite=1 in JAL, regwrite=1 in ALUWB.
- op=1111111: illegal=1 and stays in ERROR for 5+ cycles with ERR_HALT=1; with ERR_HALT=0, returns to FETCH after 1 cycle.
- Reset mid-operation: rst low during MEMWRITE -> memwrite drops to 0 immediately.
